// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: conditions three raw push-buttons,
// runs the IDLE/RUN/LAP/PAUSE state machine, prescales clk into the
// counter's count-enable tick and issues clear / lap-capture strobes.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 1000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       count_en,
  output logic       count_clr,
  output logic       lap_capture,
  output logic       lap_hold,
  output logic       running,
  output logic [1:0] state
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int TW  = $clog2(TICK_DIV);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_t;

  // Bit 0 = start/stop, bit 1 = lap, bit 2 = clear.
  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_clear, btn_lap, btn_start_stop};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic           sync1_reg;
      logic           sync2_reg;
      logic           level_reg;
      logic           level_d_reg;
      logic           press_reg;
      logic [DBW-1:0] cnt_reg;

      // Synchronize, debounce (level accepted after DB_CYCLES stable samples)
      // and turn each debounced rising edge into a one-cycle press pulse.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          level_reg   <= 1'b0;
          level_d_reg <= 1'b0;
          press_reg   <= 1'b0;
          cnt_reg     <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + DBW'(1);
          end
          level_d_reg <= level_reg;
          press_reg   <= level_reg & ~level_d_reg;
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  state_t         state_reg, state_next;
  logic           clr_next, cap_next, en_next;
  logic [TW-1:0]  presc_reg, presc_next;
  logic           start_p, clear_p, lap_p;
  logic           run_now, run_next;

  // Coincident presses: start/stop beats clear, clear beats lap.
  assign start_p = press[0];
  assign clear_p = press[2] & ~press[0];
  assign lap_p   = press[1] & ~press[0] & ~press[2];

  // Next state and the strobes that accompany each transition.
  always_comb begin
    state_next = state_reg;
    clr_next   = 1'b0;
    cap_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_p)      state_next = RUN;
        else if (clear_p) clr_next   = 1'b1;
      end
      RUN: begin
        if (start_p) begin
          state_next = PAUSE;
        end else if (lap_p) begin
          state_next = LAP;
          cap_next   = 1'b1;
        end
      end
      LAP: begin
        if (start_p)    state_next = PAUSE;
        else if (lap_p) state_next = RUN;
      end
      PAUSE: begin
        if (start_p) begin
          state_next = RUN;
        end else if (clear_p) begin
          state_next = IDLE;
          clr_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign run_now  = (state_reg == RUN) || (state_reg == LAP);
  assign run_next = (state_next == RUN) || (state_next == LAP);

  // Prescaler advances only while staying in RUN/LAP, so a pause keeps the
  // partial tick and no tick can land in the first PAUSE cycle.
  always_comb begin
    presc_next = presc_reg;
    en_next    = 1'b0;
    if (run_now && run_next) begin
      if (presc_reg == TICK_LAST) begin
        presc_next = '0;
        en_next    = 1'b1;
      end else begin
        presc_next = presc_reg + TW'(1);
      end
    end else if (state_next == IDLE) begin
      presc_next = '0;
    end
  end

  // State, prescaler and single-cycle strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      presc_reg   <= '0;
      count_en    <= 1'b0;
      count_clr   <= 1'b0;
      lap_capture <= 1'b0;
    end else begin
      state_reg   <= state_next;
      presc_reg   <= presc_next;
      count_en    <= en_next;
      count_clr   <= clr_next;
      lap_capture <= cap_next;
    end
  end

  assign state    = state_reg;
  assign lap_hold = (state_reg == LAP);
  assign running  = (state_reg == RUN) || (state_reg == LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a behavioural model pushes the
// expected output vector for every clock edge, a monitor pops and compares.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int DB = 3;

  // Transition table indexed [state][event]; event 0 none, 1 start, 2 clear, 3 lap.
  localparam int NEXT_TAB [4][4] = '{'{0, 1, 0, 0},
                                     '{1, 3, 1, 2},
                                     '{2, 3, 2, 1},
                                     '{3, 1, 0, 3}};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       b_ss = 1'b0;
  logic       b_lap = 1'b0;
  logic       b_clr = 1'b0;
  logic       count_en, count_clr, lap_capture, lap_hold, running;
  logic [1:0] state;

  stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (b_ss),
    .btn_lap        (b_lap),
    .btn_clear      (b_clr),
    .count_en       (count_en),
    .count_clr      (count_clr),
    .lap_capture    (lap_capture),
    .lap_hold       (lap_hold),
    .running        (running),
    .state          (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [6:0] exp_q[$];

  function automatic logic [6:0] pack(input int st, input bit cap, input bit clr, input bit en);
    logic [1:0] s2;
    s2 = 2'(st);
    return {s2, (st == 1 || st == 2), (st == 2), cap, clr, en};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {state, running, lap_hold, lap_capture, count_clr, count_en};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  bit [2:0] hist_q[$];   // two-edge synchronizer delay
  bit [2:0] win_q[$];    // last DB synchronized samples
  bit [2:0] m_lvl, m_lvl_d, m_press;
  int       m_state, m_acc;

  always @(posedge clk) begin : model
    int ev, nx;
    bit clr, cap, en, wr, nr, all_diff;
    bit [2:0] s, np;
    if (reset) begin
      hist_q  = '{3'b000, 3'b000};
      win_q.delete();
      m_lvl   = '0;
      m_lvl_d = '0;
      m_press = '0;
      m_state = 0;
      m_acc   = 0;
    end else begin
      ev  = m_press[0] ? 1 : m_press[2] ? 2 : m_press[1] ? 3 : 0;
      nx  = NEXT_TAB[m_state][ev];
      clr = (ev == 2) && (m_state == 0 || m_state == 3);
      cap = (ev == 3) && (m_state == 1);
      wr  = (m_state == 1 || m_state == 2);
      nr  = (nx == 1 || nx == 2);
      en  = wr && nr && ((m_acc % TD) == TD - 1);
      if (wr && nr) m_acc++;
      if (nx == 0) m_acc = 0;
      m_state = nx;

      hist_q.push_back({b_clr, b_lap, b_ss});
      s = hist_q.pop_front();
      win_q.push_back(s);
      if (win_q.size() > DB) void'(win_q.pop_front());
      np      = m_lvl & ~m_lvl_d;
      m_lvl_d = m_lvl;
      for (int b = 0; b < 3; b++) begin
        if (win_q.size() == DB) begin
          all_diff = 1'b1;
          foreach (win_q[k]) if (win_q[k][b] == m_lvl[b]) all_diff = 1'b0;
          if (all_diff) m_lvl[b] = ~m_lvl[b];
        end
      end
      m_press = np;
      exp_q.push_back(pack(nx, cap, clr, en));
    end
  end

  // ---------------- monitor ----------------
  logic [6:0] exp_last = '0;

  always @(negedge clk) begin : monitor
    logic [6:0] e, a;
    a = dut_vec();
    if (reset) begin
      exp_q.delete();
      exp_last = '0;
      e = '0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_last = e;
    end else begin
      e = exp_last;
    end
    checks++;
    if (a === e) passed++;
    else $display("FAIL scoreboard t=%0t actual st=%0d run=%0b hold=%0b cap=%0b clr=%0b en=%0b required st=%0d run=%0b hold=%0b cap=%0b clr=%0b en=%0b",
                  $time, a[6:5], a[4], a[3], a[2], a[1], a[0], e[6:5], e[4], e[3], e[2], e[1], e[0]);
  end

  // ---------------- stimulus ----------------
  task automatic set_btns(input bit [2:0] v);
    b_ss  = v[0];
    b_lap = v[1];
    b_clr = v[2];
  endtask

  task automatic press(input bit [2:0] v, input int hold);
    @(negedge clk);
    set_btns(v);
    repeat (hold) @(negedge clk);
    set_btns(3'b000);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1;
    chk("reset_outputs", {1'b0, dut_vec()}, 8'h00);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Start held: RUN visible after edge 2+DB+2, first tick TD edges later.
    @(negedge clk);
    b_ss = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 6)  chk("pre_run_state", {6'd0, state}, 8'd0);
      if (i == 7)  chk("run_state", {6'd0, state}, 8'd1);
      if (i == 10) chk("no_early_tick", {7'd0, count_en}, 8'd0);
      if (i == 11) chk("first_tick", {7'd0, count_en}, 8'd1);
    end
    @(negedge clk);
    b_ss = 1'b0;
    repeat (10) @(negedge clk);

    // Lap in, lap out.
    press(3'b010, 5);
    repeat (6) @(negedge clk);
    press(3'b010, 5);

    // Pause part-way into a tick, stay paused, resume.
    repeat (2) @(negedge clk);
    press(3'b001, 5);
    repeat (20) @(negedge clk);
    press(3'b001, 5);

    // Pause then clear to IDLE.
    press(3'b001, 5);
    press(3'b100, 5);

    // Bouncing start press, then clear in RUN (ignored).
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      b_ss = ~b_ss;
      @(negedge clk);
    end
    b_ss = 1'b1;
    repeat (8) @(negedge clk);
    b_ss = 1'b0;
    repeat (10) @(negedge clk);
    press(3'b100, 5);

    // Pause, then start and clear together.
    press(3'b001, 5);
    press(3'b101, 5);

    // Asynchronous reset mid-RUN.
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("async_reset", {1'b0, dut_vec()}, 8'h00);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    repeat (20) @(negedge clk);

    // Randomized button activity, including bounce and coincident presses.
    for (int n = 0; n < 1500; n++) begin
      bit [2:0] v;
      v = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      set_btns(v);
      repeat ($urandom_range(1, 8)) @(negedge clk);
    end
    set_btns(3'b000);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
